// File: rtl/cb_out_arbiter_if.sv
// Code-block arbiter bus: both upstream FIFO read ports and the shared downstream byte stream.
// master = arbiter side, slave = FIFO/sink side.
interface cb_out_arbiter_if;
  logic       itl_empty;
  logic       itl_rdreq;
  logic [9:0] itl_q;
  logic       enc_empty;
  logic       enc_rdreq;
  logic [9:0] enc_q;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_size;
  logic       out_start;
  logic       out_last;
  logic       out_src;

  modport master (
    input  itl_empty, itl_q, enc_empty, enc_q, out_ready,
    output itl_rdreq, enc_rdreq, out_valid, out_data, out_size, out_start, out_last, out_src
  );

  modport slave (
    output itl_empty, itl_q, enc_empty, enc_q, out_ready,
    input  itl_rdreq, enc_rdreq, out_valid, out_data, out_size, out_start, out_last, out_src
  );
endinterface

// File: rtl/cb_out_arbiter.sv
// Forwards whole code blocks from the interleaver/encoder FIFOs onto one byte stream.
// Define CB_ARB_FIXED_PRIO_EN for fixed interleaver priority instead of round-robin.
module cb_out_arbiter #(
  parameter int unsigned SIZE0_BYTES = 768,
  parameter int unsigned SIZE1_BYTES = 760
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             err_clr,
  output logic             busy,
  output logic             err_sticky,
  cb_out_arbiter_if.master bus
);
  localparam logic [9:0] Len0 = 10'(SIZE0_BYTES);
  localparam logic [9:0] Len1 = 10'(SIZE1_BYTES);

  typedef enum logic [1:0] {StIdle, StHeadRd, StHeadChk, StBody} state_e;

  typedef struct packed {
    logic       src;
    logic       size;
    logic       start;
    logic       last;
    logic [7:0] data;
  } entry_t;

  state_e     state_q, state_d;
  logic       src_q, src_d;
  logic       size_q, size_d;
  logic [9:0] len_q, len_d;
  logic [9:0] issued_q, issued_d;
  logic [9:0] pushed_q, pushed_d;
  logic       rd_pend_q;
  logic       err_q, err_set;
  entry_t     buf_q [2];
  logic [1:0] occ_q;
  entry_t     push_entry;
  logic       push, pop, rd_en, can_read;
  logic       empty_sel, any_avail, grant_src;
  logic [9:0] q_sel;
  logic [1:0] room_used;

  assign empty_sel = src_q ? bus.enc_empty : bus.itl_empty;
  assign q_sel     = src_q ? bus.enc_q : bus.itl_q;
  assign any_avail = ~bus.itl_empty | ~bus.enc_empty;
  assign pop       = (occ_q != 2'd0) & bus.out_ready;
  // The pop of this cycle frees a slot in time for the word requested now.
  assign room_used = occ_q - {1'b0, pop} + {1'b0, rd_pend_q};
  assign can_read  = room_used < 2'd2;

`ifdef CB_ARB_FIXED_PRIO_EN
  assign grant_src = bus.itl_empty;
`else
  logic rr_q;

  assign grant_src = (~bus.itl_empty & ~bus.enc_empty) ? rr_q : bus.itl_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q <= 1'b0;
    end else if (state_q == StIdle && enable && any_avail) begin
      rr_q <= ~grant_src;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    size_d     = size_q;
    len_d      = len_q;
    issued_d   = issued_q;
    pushed_d   = pushed_q;
    rd_en      = 1'b0;
    push       = 1'b0;
    err_set    = 1'b0;
    push_entry = '0;
    case (state_q)
      StIdle: begin
        if (enable && any_avail) begin
          src_d   = grant_src;
          state_d = StHeadRd;
        end
      end
      StHeadRd: begin
        if (!empty_sel && can_read) begin
          rd_en   = 1'b1;
          state_d = StHeadChk;
        end
      end
      StHeadChk: begin
        if (!q_sel[0]) begin
          err_set = 1'b1;
          state_d = StHeadRd;
        end else begin
          size_d           = q_sel[1];
          len_d            = q_sel[1] ? Len1 : Len0;
          push             = 1'b1;
          push_entry.src   = src_q;
          push_entry.size  = q_sel[1];
          push_entry.start = 1'b1;
          push_entry.last  = (len_d == 10'd1);
          push_entry.data  = q_sel[9:2];
          issued_d         = 10'd1;
          pushed_d         = 10'd1;
          state_d          = (len_d == 10'd1) ? StIdle : StBody;
        end
      end
      StBody: begin
        if (!empty_sel && (issued_q < len_q) && can_read) begin
          rd_en    = 1'b1;
          issued_d = issued_q + 10'd1;
        end
        if (rd_pend_q) begin
          push            = 1'b1;
          err_set         = q_sel[0];
          push_entry.src  = src_q;
          push_entry.size = size_q;
          push_entry.last = (pushed_q == len_q - 10'd1);
          push_entry.data = q_sel[9:2];
          pushed_d        = pushed_q + 10'd1;
          if (push_entry.last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      src_q     <= 1'b0;
      size_q    <= 1'b0;
      len_q     <= '0;
      issued_q  <= '0;
      pushed_q  <= '0;
      rd_pend_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      size_q    <= size_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      pushed_q  <= pushed_d;
      rd_pend_q <= rd_en;
      err_q     <= err_set | (err_q & ~err_clr);
    end
  end

  // Two-entry output buffer; entry 0 is the head presented downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q    <= 2'd0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      occ_q <= occ_q - {1'b0, pop} + {1'b0, push};
      if (push && (occ_q == 2'd0 || (occ_q == 2'd1 && pop))) begin
        buf_q[0] <= push_entry;
      end else if (pop) begin
        buf_q[0] <= buf_q[1];
      end
      if (push && ((occ_q == 2'd1 && !pop) || (occ_q == 2'd2 && pop))) begin
        buf_q[1] <= push_entry;
      end
    end
  end

  assign bus.itl_rdreq = rd_en & ~src_q;
  assign bus.enc_rdreq = rd_en & src_q;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_data  = buf_q[0].data;
  assign bus.out_size  = buf_q[0].size;
  assign bus.out_start = buf_q[0].start;
  assign bus.out_last  = buf_q[0].last;
  assign bus.out_src   = buf_q[0].src;
  assign busy          = (state_q != StIdle) | (occ_q != 2'd0);
  assign err_sticky    = err_q;
endmodule

// File: tb/tb_cb_out_arbiter.sv
// Scoreboard bench for cb_out_arbiter: queue-based FIFO models feed the DUT, a block-level
// arbitration model fills the expected byte queue, and a monitor checks every transfer.
module tb_cb_out_arbiter;
  localparam int S0 = 4;
  localparam int S1 = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic err_clr = 1'b0;
  logic busy, err_sticky;

  cb_out_arbiter_if bus ();

  cb_out_arbiter #(.SIZE0_BYTES(S0), .SIZE1_BYTES(S1)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .err_clr    (err_clr),
    .busy       (busy),
    .err_sticky (err_sticky),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [9:0]  itl_fifo[$];
  logic [9:0]  enc_fifo[$];
  logic [11:0] exp_q[$];     // {src, size, start, last, data}
  logic        starts_src[$];
  logic        itl_pend, enc_pend;
  logic [9:0]  itl_nxt, enc_nxt;
  int          itl_reads = 0;
  int          enc_reads = 0;
  int          xfers = 0;
  logic        rr_model = 1'b0;
  logic        err_model = 1'b0;
  int          ready_mode = 0;
  logic        stall_prev = 1'b0;
  logic [11:0] stall_word, mon_got, exp_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Upstream FIFO models: rdreq seen in a cycle -> word presented after the next rising edge.
  always @(negedge clk) begin
    itl_pend = 1'b0;
    enc_pend = 1'b0;
    if (reset) begin
      if (bus.itl_rdreq || bus.enc_rdreq)
        check("rdreq_onehot", {31'd0, bus.itl_rdreq & bus.enc_rdreq}, 0);
      if (bus.itl_rdreq) begin
        check("itl_nonempty_on_rdreq", {31'd0, itl_fifo.size() != 0}, 1);
        if (itl_fifo.size() != 0) begin
          itl_nxt = itl_fifo.pop_front();
          itl_pend = 1'b1;
          itl_reads++;
        end
      end
      if (bus.enc_rdreq) begin
        check("enc_nonempty_on_rdreq", {31'd0, enc_fifo.size() != 0}, 1);
        if (enc_fifo.size() != 0) begin
          enc_nxt = enc_fifo.pop_front();
          enc_pend = 1'b1;
          enc_reads++;
        end
      end
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.itl_q     <= '0;
      bus.enc_q     <= '0;
      bus.itl_empty <= 1'b1;
      bus.enc_empty <= 1'b1;
    end else begin
      if (itl_pend) bus.itl_q <= itl_nxt;
      if (enc_pend) bus.enc_q <= enc_nxt;
      bus.itl_empty <= (itl_fifo.size() == 0);
      bus.enc_empty <= (enc_fifo.size() == 0);
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 1) == 1);
        default: bus.out_ready = ~bus.out_ready;
      endcase
    end
  end

  // Monitor: checks hold-while-stalled and pops the scoreboard on every transfer.
  always @(negedge clk) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      mon_got = {bus.out_src, bus.out_size, bus.out_start, bus.out_last, bus.out_data};
      if (stall_prev) begin
        check("stall_valid_held", {31'd0, bus.out_valid}, 1);
        check("stall_word_held", {20'd0, mon_got}, {20'd0, stall_word});
      end
      if (bus.out_valid && bus.out_ready) begin
        xfers++;
        if (bus.out_start) starts_src.push_back(bus.out_src);
        check("exp_available", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          check("out_word", {20'd0, mon_got}, {20'd0, exp_word});
        end
      end
      stall_prev = bus.out_valid & ~bus.out_ready;
      stall_word = mon_got;
    end
  end

  task automatic push_word(input logic src, input logic [9:0] w);
    if (src) enc_fifo.push_back(w);
    else itl_fifo.push_back(w);
  endtask

  // One block = one grant; the rr model points away from the source just granted.
  task automatic add_block(input logic src, input logic size, input logic [7:0] base,
                           input bit use_base, input bit garbage, input bit mid_err);
    int         len;
    logic [7:0] d;
    logic       st;
    len = size ? S1 : S0;
    rr_model = ~src;
    if (garbage) begin
      push_word(src, {8'h55, 1'($urandom), 1'b0});
      err_model = 1'b1;
    end
    for (int i = 0; i < len; i++) begin
      d  = use_base ? base + 8'(i) : 8'($urandom);
      st = (i == 0);
      if (mid_err && i == 1) begin
        st = 1'b1;
        err_model = 1'b1;
      end
      push_word(src, {d, size, st});
      exp_q.push_back({src, size, (i == 0), (i == len - 1), d});
    end
  endtask

  task automatic load_phase(input int ni, input int ne, input int gar_pct, input int mid_pct);
    logic s;
    int   a, b;
    a = ni;
    b = ne;
    while (a > 0 || b > 0) begin
      if (a > 0 && b > 0) begin
`ifdef CB_ARB_FIXED_PRIO_EN
        s = 1'b0;
`else
        s = rr_model;
`endif
      end else begin
        s = (a > 0) ? 1'b0 : 1'b1;
      end
      if (s) b--;
      else a--;
      add_block(s, 1'($urandom), 8'h00, 1'b0, ($urandom_range(0, 99) < gar_pct),
                ($urandom_range(0, 99) < mid_pct));
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, exp_q.size() == 0 && !busy}, 1);
  endtask

  task automatic check_and_clear_err(input string name);
    check(name, {31'd0, err_sticky}, {31'd0, err_model});
    if (err_sticky) begin
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check({name, "_cleared"}, {31'd0, err_sticky}, 0);
    end
    err_model = 1'b0;
  endtask

  function automatic logic [31:0] dut_outs();
    return {18'd0, bus.out_valid, bus.out_data, bus.out_size, bus.out_start, bus.out_last,
            bus.out_src, bus.itl_rdreq, bus.enc_rdreq, busy, err_sticky};
  endfunction

  initial begin
    int         x0, r0, e0, n;
    logic [3:0] pat;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", dut_outs(), 0);
    reset = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    // Two blocks per source, both loaded before any grant.
    starts_src.delete();
    load_phase(2, 2, 0, 0);
    drain("t2_drain", 400);
`ifdef CB_ARB_FIXED_PRIO_EN
    pat = 4'b1100;
`else
    pat = 4'b1010;
`endif
    check("t2_block_count", starts_src.size(), 4);
    for (int i = 0; i < 4 && i < starts_src.size(); i++)
      check("t2_src_order", {31'd0, starts_src[i]}, {31'd0, pat[i]});

    // Single interleaver block 0xA0..0xA3.
    r0 = itl_reads;
    e0 = enc_reads;
    add_block(1'b0, 1'b0, 8'hA0, 1'b1, 1'b0, 1'b0);
    drain("t1_drain", 200);
    check("t1_itl_reads", itl_reads - r0, 4);
    check("t1_enc_reads", enc_reads - e0, 0);
    check("t1_no_err", {31'd0, err_sticky}, 0);

    // Size-1 block under a toggling ready.
    ready_mode = 2;
    add_block(1'b1, 1'b1, 8'hC0, 1'b1, 1'b0, 1'b0);
    drain("t3_drain", 200);
    ready_mode = 0;

    // Leading word without start flag is dropped and flagged.
    add_block(1'b0, 1'b0, 8'hB0, 1'b1, 1'b1, 1'b0);
    drain("t4_drain", 200);
    check_and_clear_err("t4_err");

    // Reset in the middle of a block.
    x0 = xfers;
    add_block(1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (xfers < x0 + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_two_bytes", {31'd0, xfers >= x0 + 2}, 1);
    #2 reset = 1'b0;
    #1 check("t5_async_reset_outputs", dut_outs(), 0);
    itl_fifo.delete();
    enc_fifo.delete();
    exp_q.delete();
    rr_model = 1'b0;
    err_model = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_idle_after_reset", {31'd0, busy}, 0);
    starts_src.delete();
    load_phase(1, 1, 0, 0);
    drain("t5_drain", 300);
    check("t5_first_grant_itl", {31'd0, starts_src.size() > 0 && starts_src[0] == 1'b0}, 1);

    // enable drops after the first byte: block completes, no new grant.
    x0 = xfers;
    add_block(1'b0, 1'b0, 8'hD0, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (xfers < x0 + 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    add_block(1'b1, 1'b0, 8'hE0, 1'b1, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    check("t6_first_block_only", xfers - x0, 4);
    check("t6_enc_untouched", enc_fifo.size(), 4);
    check("t6_idle", {31'd0, busy}, 0);
    enable = 1'b1;
    drain("t6_drain", 200);

    // Randomized phases.
    for (int p = 0; p < 15; p++) begin
      int ni, ne;
      ni = $urandom_range(0, 3);
      ne = $urandom_range(0, 3);
      if (ni == 0 && ne == 0) ni = 1;
      ready_mode = $urandom_range(0, 2);
      load_phase(ni, ne, 20, 15);
      drain("rand_drain", 1000);
      check("rand_fifos_empty", itl_fifo.size() + enc_fifo.size(), 0);
      check_and_clear_err("rand_err");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d",
             n_checks, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
